// File: rtl/bit_counter_pkg.sv
// Shared definitions for the population-counter pipeline: default word width,
// length-field width helper and the deserializer state type.
package bit_counter_pkg;

    localparam int DEFAULT_WIDTH = 24;

    function automatic int len_width(input int w);
        return $clog2(w + 1);
    endfunction

    typedef enum logic {
        IDLE,
        COLLECT
    } deser_state_t;

endpackage

// File: rtl/bit_stream_deserializer.sv
// Serial-to-parallel front end of the population counter: MSB-first words, early close on last_i.
// Optional running parity output enabled by `BIT_STREAM_DESERIALIZER_PARITY_EN.
//   state   | meaning
//   IDLE    | no bits held, bit_cnt == 0
//   COLLECT | partial word held, 0 < bit_cnt < WIDTH
module bit_stream_deserializer
    import bit_counter_pkg::*;
#(
    parameter  int WIDTH = DEFAULT_WIDTH,
    localparam int LEN_W = len_width(WIDTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             data_i,
    input  logic             data_val_i,
    input  logic             last_i,
    output logic [WIDTH-1:0] deser_data_o,
    output logic [LEN_W-1:0] deser_len_o,
    output logic             deser_data_val_o,
    output logic             busy_o
`ifdef BIT_STREAM_DESERIALIZER_PARITY_EN
    ,
    output logic             deser_parity_o
`endif
);

    localparam logic [WIDTH-1:0] MSB_ONE  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [LEN_W-1:0] LAST_IDX = LEN_W'(WIDTH - 1);

    deser_state_t     state_q, state_d;
    logic [LEN_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] word;
    logic [LEN_W-1:0] len_emit;
    logic             emit;

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        emit      = 1'b0;
        // word already includes the current bit so a closing bit emits without a bubble
        word      = shift_q | (data_i ? (MSB_ONE >> bit_cnt_q) : '0);
        len_emit  = bit_cnt_q + LEN_W'(1);
        case (state_q)
            IDLE: begin
                if (data_val_i) begin
                    if (last_i) begin
                        emit = 1'b1;
                    end else begin
                        shift_d   = word;
                        bit_cnt_d = LEN_W'(1);
                        state_d   = COLLECT;
                    end
                end
            end
            COLLECT: begin
                if (data_val_i) begin
                    if (last_i || (bit_cnt_q == LAST_IDX)) begin
                        emit      = 1'b1;
                        shift_d   = '0;
                        bit_cnt_d = '0;
                        state_d   = IDLE;
                    end else begin
                        shift_d   = word;
                        bit_cnt_d = len_emit;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q          <= IDLE;
            bit_cnt_q        <= '0;
            shift_q          <= '0;
            deser_data_o     <= '0;
            deser_len_o      <= '0;
            deser_data_val_o <= 1'b0;
        end else begin
            state_q          <= state_d;
            bit_cnt_q        <= bit_cnt_d;
            shift_q          <= shift_d;
            deser_data_val_o <= emit;
            if (emit) begin
                deser_data_o <= word;
                deser_len_o  <= len_emit;
            end
        end
    end

`ifdef BIT_STREAM_DESERIALIZER_PARITY_EN
    logic parity_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            parity_q       <= 1'b0;
            deser_parity_o <= 1'b0;
        end else if (data_val_i) begin
            if (emit) begin
                parity_q       <= 1'b0;
                deser_parity_o <= parity_q ^ data_i;
            end else begin
                parity_q <= parity_q ^ data_i;
            end
        end
    end
`endif

    assign busy_o = (state_q == COLLECT);

endmodule
